// File: rtl/fir_out_requant_decim.sv
// fir_out_requant_decim: warm-up discard, decimation, round/saturate requant and FWFT output FIFO
// Ports: clk, clr_n (async active-low reset), flush (sync clear of datapath/FIFO/counters),
//        in_valid/in_data (full-precision FIR samples), out_valid/out_ready/out_data (FIFO head),
//        sat_flag/ovf_flag (sticky status), status_clr (sync flag clear, set wins)
module fir_out_requant_decim #(
    parameter int IN_WIDTH   = 23,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 8,
    parameter int DECIM      = 2,
    parameter int WARMUP     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 clr_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [IN_WIDTH-1:0]  in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 sat_flag,
    output logic                 ovf_flag,
    input  logic                 status_clr
);
    localparam int WW = $clog2(WARMUP + 1) > 0 ? $clog2(WARMUP + 1) : 1;
    localparam int PW = DECIM > 1 ? $clog2(DECIM) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [WW-1:0] WARM_INIT = WW'(WARMUP);
    localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);
    localparam logic signed [IN_WIDTH:0] HALF = (IN_WIDTH + 1)'(1 << (SHIFT - 1));
    localparam logic signed [IN_WIDTH:0] QMAX = (IN_WIDTH + 1)'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [IN_WIDTH:0] QMIN = (IN_WIDTH + 1)'(-(1 << (OUT_WIDTH - 1)));
    localparam logic [OUT_WIDTH-1:0] OMAX = {1'b0, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] OMIN = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

    logic [WW-1:0]        warm;
    logic [PW-1:0]        phase;
    logic                 s1_valid;
    logic [OUT_WIDTH-1:0] s1_data;
    logic [OUT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]        wptr, rptr;
    logic [CW-1:0]        count;
    logic [OUT_WIDTH-1:0] last_data;
    logic signed [IN_WIDTH:0] sum, q;
    logic                 hi, lo, keep, empty, full, pop, wr;
    logic [OUT_WIDTH-1:0] sat_val;

    // One extra bit of headroom so adding the rounding half never wraps
    assign sum     = signed'({in_data[IN_WIDTH-1], in_data}) + HALF;
    assign q       = sum >>> SHIFT;
    assign hi      = q > QMAX;
    assign lo      = q < QMIN;
    assign sat_val = hi ? OMAX : lo ? OMIN : q[OUT_WIDTH-1:0];

    assign keep      = in_valid && warm == '0 && phase == '0;
    assign empty     = count == '0;
    assign full      = count == FULL_CNT;
    assign pop       = !empty && out_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write
    assign wr        = s1_valid && (!full || pop);
    assign out_valid = !empty;
    assign out_data  = empty ? last_data : mem[rptr];

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            warm      <= WARM_INIT;
            phase     <= '0;
            s1_valid  <= 1'b0;
            s1_data   <= '0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            last_data <= '0;
            sat_flag  <= 1'b0;
            ovf_flag  <= 1'b0;
        end else if (flush) begin
            warm     <= WARM_INIT;
            phase    <= '0;
            s1_valid <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (in_valid) begin
                if (warm != '0)
                    warm <= warm - WW'(1);
                else
                    phase <= phase == PHASE_LAST ? '0 : phase + PW'(1);
            end
            s1_valid <= keep;
            if (keep)
                s1_data <= sat_val;
            if (pop) begin
                rptr      <= rptr + AW'(1);
                last_data <= mem[rptr];
            end
            if (wr)
                wptr <= wptr + AW'(1);
            count    <= count + CW'(wr) - CW'(pop);
            sat_flag <= (sat_flag && !status_clr) || (keep && (hi || lo));
            ovf_flag <= (ovf_flag && !status_clr) || (s1_valid && full && !pop);
        end
    end

    always_ff @(posedge clk) begin
        if (clr_n && !flush && wr)
            mem[wptr] <= s1_data;
    end
endmodule

// File: tb/tb_fir_out_requant_decim.sv
// tb_fir_out_requant_decim: directed and randomized checks against a queue-based reference model
module tb_fir_out_requant_decim;
    localparam int WARMUP = 16;
    localparam int DECIM  = 2;
    localparam int DEPTH  = 4;

    logic clk = 1'b0;
    logic clr_n, flush, in_valid, out_ready, status_clr;
    logic out_valid, sat_flag, ovf_flag;
    logic [22:0] in_data;
    logic [11:0] out_data;

    int compared = 0;
    int mismatched = 0;

    int q[$];
    int popped[$];
    bit m_s1v;
    int m_s1, m_warm, m_phase, m_last;
    bit m_sat, m_ovf;

    always #5 clk = ~clk;

    fir_out_requant_decim dut (
        .clk(clk), .clr_n(clr_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .sat_flag(sat_flag), .ovf_flag(ovf_flag), .status_clr(status_clr)
    );

    task automatic chk(string tag, int got, int exp);
        compared++;
        assert (got === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // Round half up as floor((v + 128) / 256), then clamp to 12-bit signed
    function automatic int requant(int v, output bit sat);
        int s, r;
        s = v + 128;
        r = s >= 0 ? s / 256 : -((-s + 255) / 256);
        sat = r > 2047 || r < -2048;
        return r > 2047 ? 2047 : r < -2048 ? -2048 : r;
    endfunction

    task automatic model_reset();
        q.delete();
        m_s1v = 0;
        m_warm = WARMUP;
        m_phase = 0;
        m_last = 0;
        m_sat = 0;
        m_ovf = 0;
    endtask

    task automatic check_outputs(string tag);
        chk({tag, "_valid"}, int'(out_valid), int'(q.size() > 0));
        chk({tag, "_data"}, int'($signed(out_data)), q.size() > 0 ? q[0] : m_last);
        chk({tag, "_sat"}, int'(sat_flag), int'(m_sat));
        chk({tag, "_ovf"}, int'(ovf_flag), int'(m_ovf));
    endtask

    task automatic tick(string tag);
        bit pop, s_set, o_set;
        int v;
        pop = q.size() > 0 && out_ready;
        v = int'($signed(in_data));
        @(posedge clk);
        s_set = 0;
        o_set = 0;
        if (flush) begin
            q.delete();
            m_s1v = 0;
            m_phase = 0;
            m_warm = WARMUP;
        end else begin
            if (pop) begin
                m_last = q.pop_front();
                popped.push_back(m_last);
            end
            if (m_s1v) begin
                if (q.size() < DEPTH) q.push_back(m_s1);
                else o_set = 1;
            end
            m_s1v = 0;
            if (in_valid) begin
                if (m_warm > 0) m_warm--;
                else begin
                    if (m_phase == 0) begin
                        m_s1 = requant(v, s_set);
                        m_s1v = 1;
                    end
                    m_phase = (m_phase + 1) % DECIM;
                end
            end
            if (status_clr) begin
                m_sat = 0;
                m_ovf = 0;
            end
            m_sat |= s_set;
            m_ovf |= o_set;
        end
        #1;
        check_outputs(tag);
    endtask

    task automatic drive(string tag, bit v, int d, bit r, bit f, bit c);
        in_valid = v;
        in_data = d[22:0];
        out_ready = r;
        flush = f;
        status_clr = c;
        tick(tag);
    endtask

    function automatic int rnd_data();
        logic [22:0] r;
        r = 23'($urandom);
        if ($urandom_range(0, 1) == 1) r = {{3{r[19]}}, r[19:0]};
        return int'($signed(r));
    endfunction

    task automatic check_ramp(string tag);
        chk({tag, "_count"}, popped.size(), 7);
        for (int i = 0; i < 7; i++)
            if (i < popped.size()) chk({tag, "_val"}, popped[i], 16 + 2 * i);
    endtask

    task automatic run_random(int n);
        for (int i = 0; i < n; i++)
            drive("rand", $urandom_range(0, 3) != 0, rnd_data(), $urandom_range(0, 4) < 3,
                  $urandom_range(0, 99) == 0, $urandom_range(0, 39) == 0);
    endtask

    initial begin
        clr_n = 1'b0;
        flush = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b0;
        status_clr = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        #21 clr_n = 1'b1;

        // Ramp k*256: warm-up drops k<16, decimation keeps even k
        popped.delete();
        for (int k = 0; k < 30; k++) drive("ramp", 1, k * 256, 1, 0, 0);
        for (int k = 0; k < 4; k++) drive("ramp", 0, 0, 1, 0, 0);
        check_ramp("ramp");

        // Same ramp with idle cycles between accepts: phase must not move
        drive("flush", 0, 0, 1, 1, 0);
        popped.delete();
        for (int k = 0; k < 30; k++) begin
            drive("gap", 1, k * 256, 1, 0, 0);
            drive("gap", 0, 12345, 1, 0, 0);
        end
        for (int k = 0; k < 4; k++) drive("gap", 0, 0, 1, 0, 0);
        check_ramp("gap");

        // Rounding and saturation at kept positions
        begin
            int vals[10] = '{384, 0, -384, 0, 524160, 0, -524416, 0, 4194303, 0};
            int exp_q[5] = '{2, -1, 2047, -2048, 2047};
            drive("flush", 0, 0, 1, 1, 0);
            popped.delete();
            for (int k = 0; k < WARMUP; k++) drive("sat", 1, 0, 1, 0, 0);
            for (int k = 0; k < 10; k++) drive("sat", 1, vals[k], 1, 0, 0);
            for (int k = 0; k < 4; k++) drive("sat", 0, 0, 1, 0, 0);
            chk("sat_count", popped.size(), 5);
            for (int i = 0; i < 5; i++)
                if (i < popped.size()) chk("sat_val", popped[i], exp_q[i]);
            chk("sat_flag_set", int'(sat_flag), 1);
            drive("sat_clr", 0, 0, 1, 0, 1);
            chk("sat_flag_clr", int'(sat_flag), 0);
        end

        // Backpressure: six kept samples into a four-entry FIFO
        drive("flush", 0, 0, 1, 1, 0);
        drive("bp", 0, 0, 0, 0, 1);
        for (int k = 0; k < WARMUP; k++) drive("bp", 1, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) drive("bp", 1, (k + 1) * 256, 0, 0, 0);
        for (int k = 0; k < 2; k++) drive("bp", 0, 0, 0, 0, 0);
        chk("bp_ovf", int'(ovf_flag), 1);
        chk("bp_valid", int'(out_valid), 1);
        popped.delete();
        for (int k = 0; k < 6; k++) drive("bp_drain", 0, 0, 1, 0, 0);
        chk("bp_count", popped.size(), 4);
        for (int i = 0; i < 4; i++)
            if (i < popped.size()) chk("bp_order", popped[i], 2 * i + 1);
        chk("bp_empty", int'(out_valid), 0);

        // Full FIFO with a pending write and a pop on the same edge
        drive("flush", 0, 0, 1, 1, 0);
        drive("pp", 0, 0, 0, 0, 1);
        for (int k = 0; k < WARMUP; k++) drive("pp", 1, 0, 0, 0, 0);
        for (int k = 0; k < 9; k++) drive("pp", 1, k * 256, 0, 0, 0);
        popped.delete();
        drive("pp_both", 0, 0, 1, 0, 0);
        chk("pp_no_ovf", int'(ovf_flag), 0);
        for (int k = 0; k < 6; k++) drive("pp_drain", 0, 0, 1, 0, 0);
        chk("pp_count", popped.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < popped.size()) chk("pp_order", popped[i], 2 * i);

        run_random(250);

        // Async reset mid-stream: outputs clear before any clock edge
        in_valid = 1'b1;
        out_ready = 1'b1;
        #2 clr_n = 1'b0;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(posedge clk);
        @(posedge clk);
        #2 clr_n = 1'b1;

        run_random(250);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
